mac_tx_arbiter: RTL and testbench

- Frame-level round-robin arbiter that shares the single MAC TX AXIS channel between two requesters.
- Port 0 carries ARP frames; port 1 carries IP_TX frames.
- Sits between the protocol TX engines and the MAC TX input; the MAC side has no ready signal, so the arbiter back-pressures only the sources.
- Guarantees whole-frame atomicity, enforces a minimum idle gap between frames, and aborts frames whose source stalls mid-frame.

---
 rtl/eth_pkg.sv | 33 +++
 rtl/rr_arb2.sv | 44 ++++
 rtl/mac_tx_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_mac_tx_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared Ethernet TX definitions.
// Holds the AXIS width constants, the TX arbiter state encoding and the
// bit positions of the fields packed into the 80-bit MAC user sideband
// {len[15:0], src_mac[47:0], type[15:0]}.
package eth_pkg;

  localparam int DATA_W     = 64;
  localparam int KEEP_W     = 8;
  localparam int MAC_USER_W = 80;

  localparam int USER_TYPE_LSB = 0;
  localparam int USER_TYPE_W   = 16;
  localparam int USER_MAC_LSB  = 16;
  localparam int USER_MAC_W    = 48;
  localparam int USER_LEN_LSB  = 64;
  localparam int USER_LEN_W    = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DROP = 2'd2,
    GAP  = 2'd3
  } arb_state_t;

  function automatic logic [USER_LEN_W-1:0] user_len(input logic [MAC_USER_W-1:0] user);
    return user[USER_LEN_LSB +: USER_LEN_W];
  endfunction

  function automatic logic [USER_TYPE_W-1:0] user_type(input logic [MAC_USER_W-1:0] user);
    return user[USER_TYPE_LSB +: USER_TYPE_W];
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin grant logic.
// The grant is combinational from the request vector and the remembered
// last winner; the last winner only moves when the owner pulses i_update,
// so a caller can hold a grant for a whole transaction (frame) and commit
// the round-robin pointer when that transaction completes.
//
// Ports:
//   i_clk, i_rst    clock, asynchronous active-high reset
//   i_req[1:0]      request per port
//   i_update        commit strobe for the round-robin pointer
//   i_update_grant  one-hot port being committed as last winner
//   o_grant[1:0]    one-hot grant, 0 when nothing requests
module rr_arb2 (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_req,
  input  logic       i_update,
  input  logic [1:0] i_update_grant,
  output logic [1:0] o_grant
);

  // Index of the port that won last; resets to 1 so port 0 wins the
  // first contention.
  logic r_last_grant;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_last_grant <= 1'b1;
    end else if (i_update) begin
      r_last_grant <= i_update_grant[1];
    end
  end

  always_comb begin
    o_grant = 2'b00;
    unique case (i_req)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11:   o_grant = r_last_grant ? 2'b01 : 2'b10;
      default: o_grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/mac_tx_arbiter.sv
// Frame-level round-robin arbiter sharing the MAC TX AXIS channel between
// the ARP engine (port 0) and the IP TX engine (port 1).
// The MAC has no ready, so only the sources are back-pressured. A frame
// is never interleaved with another, a minimum idle gap follows every
// frame, and a source that stalls mid-frame for too long has its frame
// terminated with an empty last beat and the remainder swallowed.
//
// Ports:
//   i_clk, i_rst           clock, asynchronous active-high reset
//   s0_axis_*              ARP source (data/user/keep/last/valid, ready out)
//   s1_axis_*              IP TX source (same layout)
//   m_axis_mac_*           registered stream to the MAC (no ready)
//   o_grant[1:0]           one-hot owner of the current frame, 0 when idle
//   o_abort                one-cycle pulse alongside the abort beat
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no owner; arbitrate among valid sources
// SEND  | owner's beats forwarded one cycle later; stall timer running
// DROP  | frame aborted; owner's beats consumed until its last, no output
// GAP   | forced idle after a frame, all readies low, then back to IDLE
module mac_tx_arbiter
  import eth_pkg::*;
#(
  parameter int P_IFG_CYCLES  = 1,
  parameter int P_GAP_TIMEOUT = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,

  input  logic [DATA_W-1:0]     s0_axis_data,
  input  logic [MAC_USER_W-1:0] s0_axis_user,
  input  logic [KEEP_W-1:0]     s0_axis_keep,
  input  logic                  s0_axis_last,
  input  logic                  s0_axis_valid,
  output logic                  s0_axis_ready,

  input  logic [DATA_W-1:0]     s1_axis_data,
  input  logic [MAC_USER_W-1:0] s1_axis_user,
  input  logic [KEEP_W-1:0]     s1_axis_keep,
  input  logic                  s1_axis_last,
  input  logic                  s1_axis_valid,
  output logic                  s1_axis_ready,

  output logic [DATA_W-1:0]     m_axis_mac_data,
  output logic [MAC_USER_W-1:0] m_axis_mac_user,
  output logic [KEEP_W-1:0]     m_axis_mac_keep,
  output logic                  m_axis_mac_last,
  output logic                  m_axis_mac_valid,

  output logic [1:0]            o_grant,
  output logic                  o_abort
);

  // Stall timer fires while holding P_GAP_TIMEOUT-1, i.e. on the
  // P_GAP_TIMEOUT-th consecutive idle cycle of the owner.
  localparam logic [7:0] GAP_TC   = 8'(P_GAP_TIMEOUT - 1);
  // Inter-frame timer counts down to zero; GAP therefore lasts
  // P_IFG_CYCLES+1 cycles, which with the registered grant and the
  // output register yields last-to-first spacing of P_IFG_CYCLES+3.
  localparam logic [3:0] IFG_LOAD = 4'(P_IFG_CYCLES);

  arb_state_t state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic [7:0] gap_cnt_q, gap_cnt_d;
  logic [3:0] ifg_cnt_q, ifg_cnt_d;

  logic [1:0] arb_grant;
  logic       arb_update;
  logic       beat_load;
  logic       abort_fire;

  // Beat of the current owner; only meaningful in SEND/DROP.
  logic                  g_sel;
  logic                  g_valid;
  logic                  g_last;
  logic [DATA_W-1:0]     g_data;
  logic [MAC_USER_W-1:0] g_user;
  logic [KEEP_W-1:0]     g_keep;

  assign g_sel   = grant_q[1];
  assign g_valid = g_sel ? s1_axis_valid : s0_axis_valid;
  assign g_last  = g_sel ? s1_axis_last  : s0_axis_last;
  assign g_data  = g_sel ? s1_axis_data  : s0_axis_data;
  assign g_user  = g_sel ? s1_axis_user  : s0_axis_user;
  assign g_keep  = g_sel ? s1_axis_keep  : s0_axis_keep;

  rr_arb2 u_rr_arb2 (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_req          ({s1_axis_valid, s0_axis_valid}),
    .i_update       (arb_update),
    .i_update_grant (grant_q),
    .o_grant        (arb_grant)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      grant_q   <= 2'b00;
      gap_cnt_q <= 8'd0;
      ifg_cnt_q <= 4'd0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      gap_cnt_q <= gap_cnt_d;
      ifg_cnt_q <= ifg_cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    gap_cnt_d     = gap_cnt_q;
    ifg_cnt_d     = ifg_cnt_q;
    arb_update    = 1'b0;
    beat_load     = 1'b0;
    abort_fire    = 1'b0;
    s0_axis_ready = 1'b0;
    s1_axis_ready = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (arb_grant != 2'b00) begin
          grant_d   = arb_grant;
          gap_cnt_d = 8'd0;
          state_d   = SEND;
        end
      end

      SEND: begin
        s0_axis_ready = grant_q[0];
        s1_axis_ready = grant_q[1];
        if (g_valid) begin
          beat_load = 1'b1;
          gap_cnt_d = 8'd0;
          if (g_last) begin
            arb_update = 1'b1;
            grant_d    = 2'b00;
            ifg_cnt_d  = IFG_LOAD;
            state_d    = GAP;
          end
        end else if (gap_cnt_q == GAP_TC) begin
          abort_fire = 1'b1;
          gap_cnt_d  = 8'd0;
          state_d    = DROP;
        end else begin
          gap_cnt_d = gap_cnt_q + 8'd1;
        end
      end

      DROP: begin
        s0_axis_ready = grant_q[0];
        s1_axis_ready = grant_q[1];
        if (g_valid && g_last) begin
          arb_update = 1'b1;
          grant_d    = 2'b00;
          ifg_cnt_d  = IFG_LOAD;
          state_d    = GAP;
        end
      end

      GAP: begin
        if (ifg_cnt_q == 4'd0) begin
          state_d = IDLE;
        end else begin
          ifg_cnt_d = ifg_cnt_q - 4'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign o_grant = grant_q;

  // Output register stage. Data/user/keep hold between beats so the abort
  // beat can reuse the user of the last forwarded beat.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      m_axis_mac_data  <= '0;
      m_axis_mac_user  <= '0;
      m_axis_mac_keep  <= '0;
      m_axis_mac_last  <= 1'b0;
      m_axis_mac_valid <= 1'b0;
      o_abort          <= 1'b0;
    end else begin
      m_axis_mac_valid <= beat_load | abort_fire;
      m_axis_mac_last  <= beat_load ? g_last : abort_fire;
      o_abort          <= abort_fire;
      if (beat_load) begin
        m_axis_mac_data <= g_data;
        m_axis_mac_user <= g_user;
        m_axis_mac_keep <= g_keep;
      end else if (abort_fire) begin
        m_axis_mac_data <= '0;
        m_axis_mac_keep <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mac_tx_arbiter.sv
module tb_mac_tx_arbiter;

  localparam int PI = 1;
  localparam int PG = 16;

  typedef struct {
    logic [63:0] data;
    logic [79:0] user;
    logic [7:0]  keep;
    logic        last;
    int          stall;
  } beat_t;

  typedef struct {
    int          cyc;
    logic [63:0] data;
    logic [79:0] user;
    logic [7:0]  keep;
    logic        last;
    logic [1:0]  grant;
    logic        abort;
  } obs_t;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [63:0] s_data  [2];
  logic [79:0] s_user  [2];
  logic [7:0]  s_keep  [2];
  logic        s_last  [2];
  logic        s_valid [2];
  logic        s_ready [2];
  logic [63:0] m_data;
  logic [79:0] m_user;
  logic [7:0]  m_keep;
  logic        m_last, m_valid, o_abort;
  logic [1:0]  o_grant;

  mac_tx_arbiter #(.P_IFG_CYCLES(PI), .P_GAP_TIMEOUT(PG)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .s0_axis_data(s_data[0]), .s0_axis_user(s_user[0]), .s0_axis_keep(s_keep[0]),
    .s0_axis_last(s_last[0]), .s0_axis_valid(s_valid[0]), .s0_axis_ready(s_ready[0]),
    .s1_axis_data(s_data[1]), .s1_axis_user(s_user[1]), .s1_axis_keep(s_keep[1]),
    .s1_axis_last(s_last[1]), .s1_axis_valid(s_valid[1]), .s1_axis_ready(s_ready[1]),
    .m_axis_mac_data(m_data), .m_axis_mac_user(m_user), .m_axis_mac_keep(m_keep),
    .m_axis_mac_last(m_last), .m_axis_mac_valid(m_valid),
    .o_grant(o_grant), .o_abort(o_abort)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  beat_t q0[$], q1[$];
  obs_t  obs[$], exp_q[$];
  int checks = 0, errors = 0;
  int abort_seen = 0, overlap = 0, exp_aborts = 0;
  int model_lg = 1;
  int consumed;

  always @(negedge i_clk) begin
    if (!i_rst) begin
      if (m_valid) obs.push_back('{cyc, m_data, m_user, m_keep, m_last, o_grant, o_abort});
      if (o_abort) abort_seen++;
      if (s_ready[0] && s_ready[1]) overlap++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
    end
  endtask

  function automatic beat_t get_beat(input int p, input int i);
    if (p == 0) return q0[i];
    return q1[i];
  endfunction

  function automatic logic [1:0] onehot(input int p);
    return (p == 0) ? 2'b01 : 2'b10;
  endfunction

  task automatic add_frame(input int p, input int nb, input int stall_at, input int stall_len,
                           input logic [7:0] last_keep);
    beat_t b;
    logic [47:0] mac;
    mac = {16'($urandom), 32'($urandom)};
    for (int j = 0; j < nb; j++) begin
      b.data  = {32'($urandom), 32'($urandom)};
      b.user  = {16'(nb * 8), mac, (p == 0) ? 16'h0806 : 16'h0800};
      b.keep  = (j == nb - 1) ? last_keep : 8'hFF;
      b.last  = (j == nb - 1);
      b.stall = (j > 0 && j == stall_at) ? stall_len : 0;
      if (p == 0) q0.push_back(b); else q1.push_back(b);
    end
  endtask

  // Frame-level reference: a frame offered at IDLE cycle c has its first
  // beat accepted at c+1; each later beat k cycles of stall after the
  // previous one; outputs appear one cycle after acceptance; a stall of PG
  // or more aborts PG+1 cycles after the last accepted beat; the next
  // arbitration happens PI+2 cycles after the frame's last acceptance.
  task automatic build_expected(input int c0);
    int i[2];
    int n[2];
    int c, p, acc, prev_acc;
    bit aborted, first;
    beat_t b;
    logic [79:0] prev_user;
    exp_q.delete();
    exp_aborts = 0;
    n[0] = q0.size(); n[1] = q1.size();
    i[0] = 0; i[1] = 0;
    c = c0;
    while (i[0] < n[0] || i[1] < n[1]) begin
      if (i[0] < n[0] && i[1] < n[1]) p = (model_lg == 0) ? 1 : 0;
      else p = (i[0] < n[0]) ? 0 : 1;
      aborted = 0; first = 1; prev_acc = c; prev_user = '0;
      while (1) begin
        b = get_beat(p, i[p]);
        if (first) acc = c + 1;
        else begin
          if (!aborted && b.stall >= PG) begin
            exp_q.push_back('{prev_acc + PG + 1, 64'h0, prev_user, 8'h00, 1'b1, onehot(p), 1'b1});
            exp_aborts++;
            aborted = 1;
          end
          acc = prev_acc + b.stall + 1;
        end
        if (!aborted)
          exp_q.push_back('{acc + 1, b.data, b.user, b.keep, b.last,
                            b.last ? 2'b00 : onehot(p), 1'b0});
        prev_acc = acc; prev_user = b.user; first = 0;
        i[p]++;
        if (b.last) break;
      end
      model_lg = p;
      c = prev_acc + PI + 2;
    end
  endtask

  task automatic run_traffic(input int rst_at, output int c_start);
    int idx[2];
    int n[2];
    int stall_left[2];
    bit vld[2];
    bit rdy[2];
    int drain, steps;
    beat_t b;
    n[0] = q0.size(); n[1] = q1.size();
    idx[0] = 0; idx[1] = 0; stall_left[0] = 0; stall_left[1] = 0;
    drain = 0; steps = 0;
    @(negedge i_clk);
    obs.delete(); abort_seen = 0; overlap = 0;
    c_start = cyc;
    while (1) begin
      for (int p = 0; p < 2; p++) begin
        if (idx[p] < n[p] && stall_left[p] == 0) begin
          b = get_beat(p, idx[p]);
          s_data[p] = b.data; s_user[p] = b.user; s_keep[p] = b.keep; s_last[p] = b.last;
          s_valid[p] = 1'b1; vld[p] = 1'b1;
        end else begin
          s_valid[p] = 1'b0; vld[p] = 1'b0;
        end
      end
      if (rst_at >= 0 && cyc == c_start + rst_at) begin
        #2 i_rst = 1'b1;
        #1;
        chk("rst_async_m_valid", m_valid, 0);
        chk("rst_async_m_last", m_last, 0);
        chk("rst_async_m_keep", m_keep, 0);
        chk("rst_async_o_grant", o_grant, 0);
        chk("rst_async_ready1", s_ready[1], 0);
        @(negedge i_clk);
        s_valid[0] = 1'b0; s_valid[1] = 1'b0;
        i_rst = 1'b0;
        break;
      end
      #1;
      rdy[0] = s_ready[0]; rdy[1] = s_ready[1];
      @(posedge i_clk);
      for (int p = 0; p < 2; p++) begin
        if (vld[p] && rdy[p]) begin
          idx[p]++;
          if (idx[p] < n[p]) stall_left[p] = get_beat(p, idx[p]).stall;
        end else if (!vld[p] && stall_left[p] > 0) begin
          stall_left[p]--;
        end
      end
      @(negedge i_clk);
      steps++;
      if (idx[0] == n[0] && idx[1] == n[1]) drain++;
      if (drain >= 25 || steps >= 3000) break;
    end
    s_valid[0] = 1'b0; s_valid[1] = 1'b0;
    consumed = (idx[0] == n[0] && idx[1] == n[1]) ? 1 : 0;
  endtask

  task automatic compare_run(input string tag);
    int m;
    chk({tag, "_consumed"}, consumed, 1);
    chk({tag, "_beats"}, obs.size(), exp_q.size());
    m = (obs.size() < exp_q.size()) ? obs.size() : exp_q.size();
    for (int k = 0; k < m; k++) begin
      chk($sformatf("%s_cyc%0d", tag, k),   obs[k].cyc,   exp_q[k].cyc);
      chk($sformatf("%s_data%0d", tag, k),  obs[k].data,  exp_q[k].data);
      chk($sformatf("%s_user%0d", tag, k),  obs[k].user,  exp_q[k].user);
      chk($sformatf("%s_keep%0d", tag, k),  obs[k].keep,  exp_q[k].keep);
      chk($sformatf("%s_last%0d", tag, k),  obs[k].last,  exp_q[k].last);
      chk($sformatf("%s_grant%0d", tag, k), obs[k].grant, exp_q[k].grant);
      chk($sformatf("%s_abort%0d", tag, k), obs[k].abort, exp_q[k].abort);
    end
    chk({tag, "_abort_pulses"}, abort_seen, exp_aborts);
    chk({tag, "_ready_overlap"}, overlap, 0);
  endtask

  task automatic scenario(input string tag);
    int c0;
    run_traffic(-1, c0);
    build_expected(c0);
    compare_run(tag);
    if (tag == "only_s0" && obs.size() > 0) chk("only_s0_first_latency", obs[0].cyc - c0, 2);
    if (tag == "b2b")
      for (int k = 1; k < obs.size(); k++)
        chk($sformatf("b2b_spacing%0d", k), obs[k].cyc - obs[k-1].cyc, PI + 3);
    q0.delete(); q1.delete();
  endtask

  int st_tab[6] = '{1, 2, 3, 15, 16, 20};

  initial begin
    int c0, nf, nb, sa;
    s_valid[0] = 1'b0; s_valid[1] = 1'b0;
    for (int p = 0; p < 2; p++) begin
      s_data[p] = '0; s_user[p] = '0; s_keep[p] = '0; s_last[p] = 1'b0;
    end
    repeat (3) @(negedge i_clk);
    chk("reset_m_valid", m_valid, 0);
    chk("reset_m_last", m_last, 0);
    chk("reset_m_data", m_data, 0);
    chk("reset_m_user", m_user, 0);
    chk("reset_m_keep", m_keep, 0);
    chk("reset_o_grant", o_grant, 0);
    chk("reset_o_abort", o_abort, 0);
    chk("reset_ready0", s_ready[0], 0);
    chk("reset_ready1", s_ready[1], 0);
    i_rst = 1'b0;
    model_lg = 1;
    repeat (2) @(negedge i_clk);

    add_frame(0, 2, 0, 0, 8'h3F);
    add_frame(1, 3, 0, 0, 8'h07);
    scenario("contend_after_reset");

    add_frame(0, 3, 0, 0, 8'h0F);
    scenario("only_s0");

    add_frame(0, 2, 0, 0, 8'h01);
    add_frame(1, 2, 0, 0, 8'h03);
    scenario("second_contention");

    add_frame(1, 5, 2, 3, 8'hFF);
    scenario("stall_3");

    add_frame(1, 5, 2, PG + 4, 8'h1F);
    add_frame(0, 1, 0, 0, 8'hFF);
    scenario("abort");

    for (int f = 0; f < 4; f++) begin
      add_frame(0, 1, 0, 0, 8'hFF);
      add_frame(1, 1, 0, 0, 8'hFF);
    end
    scenario("b2b");

    for (int r = 0; r < 6; r++) begin
      for (int p = 0; p < 2; p++) begin
        nf = $urandom_range(0, 3);
        for (int f = 0; f < nf; f++) begin
          nb = $urandom_range(1, 6);
          sa = (nb > 1 && $urandom_range(0, 2) == 0) ? $urandom_range(1, nb - 1) : 0;
          add_frame(p, nb, sa, st_tab[$urandom_range(0, 5)], 8'($urandom));
        end
      end
      scenario($sformatf("rand%0d", r));
    end

    add_frame(0, 2, 0, 0, 8'hFF);
    scenario("pre_reset_s0");
    add_frame(1, 6, 0, 0, 8'hFF);
    run_traffic(4, c0);
    chk("rst_beats_before_reset", obs.size(), 3);
    q0.delete(); q1.delete();
    model_lg = 1;
    repeat (2) @(negedge i_clk);
    add_frame(0, 6, 0, 0, 8'h7F);
    add_frame(1, 2, 0, 0, 8'hFF);
    scenario("post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
